// File: rtl/inst_buffer.sv
// In-order instruction buffer between fetch and N-wide decode: compacts valid
// fetch lanes into a circular queue and presents the oldest N entries to dispatch.
package inst_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        predict_taken;
        logic [31:0] predict_target;
    } IF_ID_PACKET;
endpackage

`ifndef N
`define N 3
`endif

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int N     = `N,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  IF_ID_PACKET [N-1:0]          in_packet,
    output logic                         in_accept,
    output logic [$clog2(DEPTH+1)-1:0]   free_slots,
    output IF_ID_PACKET [N-1:0]          out_packet,
    input  logic [$clog2(N+1)-1:0]       dispatch_count,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;
    IF_ID_PACKET          r_mem [DEPTH];

    logic [CW-1:0]        w_k;
    logic [CW-1:0]        w_d;
    logic [CW-1:0]        w_free;
    logic [N-1:0][PW-1:0] w_off;

    // w_off[i] is the number of valid lanes below i, i.e. the slot offset from tail.
    always_comb begin
        w_k   = '0;
        w_off = '0;
        for (int i = 0; i < N; i++) begin
            w_off[i] = w_k[PW-1:0];
            w_k      = w_k + CW'(in_packet[i].valid);
        end
    end

    // Free space comes from the registered count only, so same-cycle dequeues
    // never make room for a same-cycle enqueue.
    assign w_free     = CW'(DEPTH) - r_count;
    assign in_accept  = ~squash && (w_k <= w_free);
    assign free_slots = w_free;
    assign count      = r_count;

    always_comb begin
        w_d = CW'(dispatch_count);
        if (w_d > r_count) w_d = r_count;
        if (w_d > CW'(N))  w_d = CW'(N);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_d[PW-1:0];
            if (in_accept)
                r_tail <= r_tail + w_k[PW-1:0];
            r_count <= r_count + (in_accept ? w_k : '0) - w_d;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (in_accept && in_packet[i].valid)
                r_mem[r_tail + w_off[i]] <= in_packet[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_packet[i]       = r_mem[r_head + PW'(i)];
            out_packet[i].valid = (CW'(i) < r_count);
        end
    end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Parametrised in-order instruction buffer between fetch and the N-wide decode stage. It accepts up to N fetched `IF_ID_PACKET`s per cycle and compacts their valid lanes into a circular queue of DEPTH entries. It presents the oldest up to N entries to the decoders and retires however many the dispatch side consumed that cycle. Fetch and dispatch are decoupled: partial dispatch, fetch backpressure and squash-on-mispredict are all handled here.

## Interface
- `N`, default `` `N ``: lanes per cycle in each direction (≥1).
- `DEPTH`, default 16: queue entries; power of two, ≥ 2·N.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock, reset asynchronous and active-low.
- `squash`  in  1  flush all entries (branch mispredict / exception).
- `in_packet`  in  N × `IF_ID_PACKET`  fetched instructions; lanes with `.valid`=1 are candidates, and need not be contiguous.
- `in_accept`  out  1  the current `in_packet` group is accepted this cycle.
- `free_slots`  out  clog2(DEPTH+1)  empty entries, from registered count only.
- `out_packet`  out  N × `IF_ID_PACKET`  oldest entries; lane i holds entry head+i; `.valid`=(i < count).
- `dispatch_count`  in  clog2(N+1)  entries consumed from `out_packet` lanes 0..dispatch_count-1 this cycle.
- `count`  out  clog2(DEPTH+1)  occupied entries.

## Operation
- State: head and tail pointers (clog2(DEPTH) bits, wrap modulo DEPTH), count register, DEPTH-entry packet array.
- **Enqueue**
  - k = popcount of `in_packet[*].valid`.
  - `in_accept` = ~squash && (k ≤ free_slots). The rule is all-or-nothing: a group is never partially accepted.
  - When k = 0, `in_accept` = 1 and has no effect.
  - On accept, valid lanes are written in ascending lane order to tail, tail+1, …, tail+k-1 (mod DEPTH), and tail advances by k.
  - Invalid lanes never occupy an entry.
- **Dequeue**
  - d = min(`dispatch_count`, count, N).
  - Head advances by d (mod DEPTH).
  - A `dispatch_count` larger than the valid lanes is clamped, never underflows.
- **Count update**: count_next = count + (accepted ? k : 0) − d.
- **Free space**: `free_slots` = DEPTH − count from the registered count. Entries freed by a same-cycle dequeue are not usable for enqueue until the next cycle.
  - Consequence: when full (count = DEPTH), enqueue with k>0 is rejected even if d>0 in the same cycle.
- **Output lanes**
  - `out_packet[i]` = array[(head+i) mod DEPTH] with `.valid` forced to (i < count).
  - All other fields pass through unmodified: inst, PC, NPC, predict_taken, predict_target.
  - Lanes i ≥ count have `.valid`=0; other fields are don't-care.
- **Squash** (highest priority)
  - head, tail and count all go to 0.
  - Same-cycle enqueue is discarded (`in_accept`=0) and same-cycle dequeue is ignored.
  - Array contents are not cleared.
- **Reset** (asynchronous, any time, including mid-operation): head=tail=count=0. The array needs no reset.

## Timing
- Outputs are combinational from registered state only: `out_packet`, `free_slots` and `count` have no input→output combinational path.
- `in_accept` is the only combinational output; it depends on `squash`, `in_packet` valid bits and `free_slots`.
- Enqueue→visible latency is 1 cycle, with no bypass. A packet accepted at edge t appears on `out_packet` in the cycle after edge t.
- Dequeue takes effect at the edge. The next oldest entries shift to lane 0 in the following cycle.
- Squash asserted in cycle t: all `out_packet` lanes are invalid and `free_slots`=DEPTH from the cycle after edge t.
- Reset values while `reset`=0 and afterwards until the first enqueue:
  - `count`=0, `free_slots`=DEPTH
  - all `out_packet[*].valid`=0
  - `in_accept`=1 iff k=0 or k ≤ DEPTH, with `squash`=0.
- Throughput is N in and N out per cycle at steady state, provided count ≥ N and free_slots ≥ N.

## Test plan
All scenarios use N=3, DEPTH=8.

- **Reset/basic fill**
  - Stimulus: release reset; enqueue PCs 0x0,0x4,0x8 with all valid and dispatch_count=0.
  - Next cycle: count=3, free_slots=5, out lanes 0..2 = PC 0x0/0x4/0x8, all valid.
- **Sparse compaction + partial dispatch**
  - Stimulus: enqueue lanes {1,2} valid (PC 0x10,0x14) into the filled queue while dispatch_count=2.
  - Next cycle: count=3, out lanes = 0x8,0x10,0x14.
- **Full/backpressure**
  - Stimulus: fill to count=7, then offer k=2 with dispatch_count=3.
  - Required: in_accept=0; next cycle count=4, no new entries.
  - Stimulus: offer the same group again.
  - Required: in_accept=1; count becomes 6.
- **Wrap-around**
  - Stimulus: stream 12 sequential PCs (0x0…0x2C) with dispatch_count=3 every cycle.
  - Required: output order is strictly 0x0…0x2C, and pointers wrap past entry 7 with no duplication or loss.
- **Squash with simultaneous traffic**
  - Stimulus: count=5; assert squash with k=3 valid and dispatch_count=2.
  - Required: in_accept=0; next cycle count=0, free_slots=8, all out valid=0.
- **Async reset mid-stream**
  - Stimulus: drive reset=0 between edges while count=6.
  - Required: count reads 0 and out valid=0 immediately, without waiting for a clock edge.
- **Dispatch clamp**
  - Stimulus: count=1, dispatch_count=3.
  - Required: next cycle count=0 (no underflow), free_slots=8.
